// File: rtl/mem_access_unit.sv
// MEM stage of the pipelined MIPS datapath: runs a req/ack data-memory transaction
// with timeout, stalls upstream while it is outstanding, and registers the MEM/WB outputs.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemDataIn,
  input  logic [4:0]  rdRegIn,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  input  logic [1:0]  dataTypeIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [29:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        Stall,
  output logic [31:0] WriteDataOut,
  output logic [4:0]  rdRegOut,
  output logic        RegWriteOut,
  output logic        AlignErr,
  output logic        BusErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [7:0]  count_r;
  logic [31:0] ld_buf_r;
  logic        access_s;
  logic        is_load_s;
  logic        misalign_s;
  logic [3:0]  byte_en_s;
  logic [31:0] wdata_s;

  function automatic logic [31:0] load_extract(input logic [31:0] data,
                                               input logic [1:0]  off,
                                               input logic [1:0]  dt);
    logic [31:0] lane;
    lane = data >> {off, 3'b000};
    case (dt)
      2'b01:   load_extract = {{16{lane[15]}}, lane[15:0]};
      2'b10:   load_extract = {{24{lane[7]}}, lane[7:0]};
      2'b11:   load_extract = {24'h000000, lane[7:0]};
      default: load_extract = data;
    endcase
  endfunction

  assign access_s  = MemReadIn | MemWriteIn;
  assign is_load_s = MemReadIn & ~MemWriteIn;

  // Byte lanes, replicated store data and alignment check for the current access
  always_comb begin
    byte_en_s  = 4'b1111;
    wdata_s    = MemDataIn;
    misalign_s = 1'b0;
    case (dataTypeIn)
      2'b00: begin
        byte_en_s  = 4'b1111;
        wdata_s    = MemDataIn;
        misalign_s = (ALUResultIn[1:0] != 2'b00);
      end
      2'b01: begin
        byte_en_s  = 4'b0011 << ALUResultIn[1:0];
        wdata_s    = {2{MemDataIn[15:0]}};
        misalign_s = ALUResultIn[0];
      end
      default: begin
        byte_en_s  = 4'b0001 << ALUResultIn[1:0];
        wdata_s    = {4{MemDataIn[7:0]}};
        misalign_s = 1'b0;
      end
    endcase
  end

  // Reset is gated in so a transaction abandoned by reset releases the pipeline at once
  assign Stall = Rst_n & ((state_r == WAIT) ||
                          ((state_r == IDLE) && access_s && !misalign_s));

  // Transaction FSM with registered memory-side and writeback outputs
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r      <= IDLE;
      count_r      <= 8'd0;
      ld_buf_r     <= 32'd0;
      MemReq       <= 1'b0;
      MemWe        <= 1'b0;
      MemAddr      <= 30'd0;
      MemByteEn    <= 4'd0;
      MemWData     <= 32'd0;
      WriteDataOut <= 32'd0;
      rdRegOut     <= 5'd0;
      RegWriteOut  <= 1'b0;
      AlignErr     <= 1'b0;
      BusErr       <= 1'b0;
    end else begin
      AlignErr <= 1'b0;
      BusErr   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!access_s) begin
            WriteDataOut <= ALUResultIn;
            rdRegOut     <= rdRegIn;
            RegWriteOut  <= RegWriteIn;
          end else if (misalign_s) begin
            AlignErr     <= 1'b1;
            WriteDataOut <= ALUResultIn;
            rdRegOut     <= rdRegIn;
            RegWriteOut  <= 1'b0;
          end else begin
            state_r     <= WAIT;
            MemReq      <= 1'b1;
            MemWe       <= MemWriteIn;
            MemAddr     <= ALUResultIn[31:2];
            MemByteEn   <= byte_en_s;
            MemWData    <= wdata_s;
            count_r     <= 8'd0;
            RegWriteOut <= 1'b0;
          end
        end
        WAIT: begin
          RegWriteOut <= 1'b0;
          // An ack in the expiring cycle still wins over the timeout
          if (MemAck) begin
            MemReq   <= 1'b0;
            ld_buf_r <= MemRData;
            state_r  <= DONE;
          end else if (count_r >= LAST_COUNT) begin
            MemReq  <= 1'b0;
            BusErr  <= 1'b1;
            state_r <= IDLE;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        DONE: begin
          WriteDataOut <= (MemToRegIn && is_load_s)
                          ? load_extract(ld_buf_r, ALUResultIn[1:0], dataTypeIn)
                          : ALUResultIn;
          rdRegOut     <= rdRegIn;
          RegWriteOut  <= RegWriteIn & ~MemWriteIn;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          MemReq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions push expected memory
// requests and writeback results; a monitor pops and compares as the DUT presents them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] ALUResultIn = 32'd0;
  logic [31:0] MemDataIn = 32'd0;
  logic [4:0]  rdRegIn = 5'd0;
  logic        RegWriteIn = 1'b0;
  logic        MemReadIn = 1'b0;
  logic        MemWriteIn = 1'b0;
  logic        MemToRegIn = 1'b0;
  logic [1:0]  dataTypeIn = 2'b00;
  logic        MemReq, MemWe, Stall, RegWriteOut, AlignErr, BusErr;
  logic [29:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWData, WriteDataOut;
  logic [31:0] MemRData = 32'd0;
  logic        MemAck = 1'b0;
  logic [4:0]  rdRegOut;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .Rst_n(Rst_n), .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn),
    .rdRegIn(rdRegIn), .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .MemToRegIn(MemToRegIn), .dataTypeIn(dataTypeIn),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemByteEn(MemByteEn),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall),
    .WriteDataOut(WriteDataOut), .rdRegOut(rdRegOut), .RegWriteOut(RegWriteOut),
    .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [4:0]  rd;
    logic        chk_rd;
    logic        we;
    logic        align;
    logic        bus;
    int          stall;
    int          req;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ex_valid = 1'b0;
  logic retire_q = 1'b0;
  int   ack_delay = -1;
  logic [31:0] ack_data = 32'd0;
  logic force_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic we, input logic [29:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic exp_wb(input logic [31:0] wdata, input logic chk_wdata, input logic [4:0] rd,
                        input logic chk_rd, input logic we, input logic align, input logic bus,
                        input int stall, input int req);
    wb_t w;
    w.wdata = wdata; w.chk_wdata = chk_wdata; w.rd = rd; w.chk_rd = chk_rd; w.we = we;
    w.align = align; w.bus = bus; w.stall = stall; w.req = req;
    wb_q.push_back(w);
  endtask

  task automatic set_idle();
    ex_valid = 1'b0; ALUResultIn = 32'd0; MemDataIn = 32'd0; rdRegIn = 5'd0;
    RegWriteIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0; MemToRegIn = 1'b0;
    dataTypeIn = 2'b00;
  endtask

  task automatic apply(input logic [31:0] alu, input logic [31:0] mdata, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [1:0] dt, input int delay, input logic [31:0] rdata);
    ALUResultIn = alu; MemDataIn = mdata; rdRegIn = rd; RegWriteIn = rw;
    MemReadIn = mr; MemWriteIn = mw; MemToRegIn = m2r; dataTypeIn = dt;
    ack_delay = delay; ack_data = rdata; ex_valid = 1'b1;
  endtask

  // Called at negedge+1; holds the instruction until it retires or times out.
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] mdata, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw, input logic m2r,
                           input logic [1:0] dt, input int delay, input logic [31:0] rdata);
    int budget;
    budget = 0;
    apply(alu, mdata, rd, rw, mr, mw, m2r, dt, delay, rdata);
    forever begin
      #1;
      if (BusErr || !Stall) break;
      if (budget > 40) begin
        checks++; errors++;
        $display("FAIL stall_bound: stall still %b after %0d cycles, expected release", Stall, budget);
        break;
      end
      @(negedge clk); #1;
      budget++;
    end
    if (BusErr) set_idle();
    @(negedge clk); #1;
    set_idle();
  endtask

  // Memory responder: acks after ack_delay cycles of MemReq
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (MemReq) begin
        MemAck   = (wait_cnt == ack_delay);
        MemRData = (wait_cnt == ack_delay) ? ack_data : 32'hXXXX_XXXX;
        wait_cnt++;
      end else begin
        MemAck   = force_ack;
        MemRData = 32'h5A5A_5A5A;
        wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) retire_q <= ex_valid && !Stall;

  // Monitor: pops expected requests on MemReq rise and results on retire/BusErr
  initial begin
    int   stall_acc, req_acc;
    logic req_prev;
    req_t r;
    wb_t  w;
    stall_acc = 0; req_acc = 0; req_prev = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (!Rst_n) begin
        stall_acc = 0; req_acc = 0; req_prev = 1'b0;
      end else begin
        if (MemReq && !req_prev) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h, expected no request", MemAddr);
          end else begin
            r = req_q.pop_front();
            check("req_we", 32'(MemWe), 32'(r.we));
            check("req_addr", 32'(MemAddr), 32'(r.addr));
            check("req_be", 32'(MemByteEn), 32'(r.be));
            check("req_wdata", MemWData, r.wdata);
          end
        end
        req_prev = MemReq;
        if (retire_q || BusErr) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb: got wdata %h, expected no result", WriteDataOut);
          end else begin
            w = wb_q.pop_front();
            if (w.chk_wdata) check("wb_data", WriteDataOut, w.wdata);
            if (w.chk_rd) check("wb_rd", 32'(rdRegOut), 32'(w.rd));
            check("wb_regwrite", 32'(RegWriteOut), 32'(w.we));
            check("wb_alignerr", 32'(AlignErr), 32'(w.align));
            check("wb_buserr", 32'(BusErr), 32'(w.bus));
            check("stall_cycles", 32'(stall_acc), 32'(w.stall));
            check("req_cycles", 32'(req_acc), 32'(w.req));
          end
          stall_acc = 0; req_acc = 0;
        end else if (AlignErr) begin
          checks++; errors++;
          $display("FAIL align_pulse: got AlignErr 1, expected 0 outside a retire");
        end
        if (Stall) stall_acc++;
        if (MemReq) req_acc++;
      end
    end
  end

  initial begin
    set_idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_wdata", WriteDataOut, 32'd0);
    check("rst_regs", {25'd0, rdRegOut, RegWriteOut, AlignErr}, 32'd0);
    check("rst_buserr", 32'(BusErr), 32'd0);
    Rst_n = 1'b1;

    // Pass-through ALU result
    exp_wb(32'h0000_1234, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1, 32'd0);

    // lb at 0x103, ack in the last permitted WAIT cycle
    exp_req(1'b0, 30'h40, 4'b1000, 32'h0000_0000);
    exp_wb(32'hFFFF_FF80, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5, 4);
    run_instr(32'h0000_0103, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 3, 32'h80FF_0000);

    // sh at 0x202, immediate ack
    exp_req(1'b1, 30'h80, 4'b1100, 32'hBEEF_BEEF);
    exp_wb(32'h0000_0202, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1);
    run_instr(32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 0, 32'd0);

    // Misaligned lw and sh
    exp_wb(32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(32'h0000_0101, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 0, 32'd0);
    exp_wb(32'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(32'h0000_0203, 32'h1111_2222, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 0, 32'd0);

    // lh sign-extends upper half; lbu zero-extends lane 2
    exp_req(1'b0, 30'h41, 4'b1100, 32'h0000_0000);
    exp_wb(32'hFFFF_8001, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 3, 2);
    run_instr(32'h0000_0106, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1, 32'h8001_7FFF);
    exp_req(1'b0, 30'h3F, 4'b0100, 32'h0000_0000);
    exp_wb(32'h0000_00C3, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 4, 3);
    run_instr(32'h0000_00FE, 32'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2, 32'h12C3_4567);

    // lw word; lw with MemToReg=0 writes the address back
    exp_req(1'b0, 30'h80, 4'b1111, 32'h1111_1111);
    exp_wb(32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1);
    run_instr(32'h0000_0200, 32'h1111_1111, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 0, 32'hDEAD_BEEF);
    exp_req(1'b0, 30'hC0, 4'b1111, 32'h0000_0000);
    exp_wb(32'h0000_0300, 1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1);
    run_instr(32'h0000_0300, 32'd0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 0, 32'h0000_0055);

    // Read and write both set: store wins
    exp_req(1'b1, 30'hC0, 4'b0010, 32'h5A5A_5A5A);
    exp_wb(32'h0000_0301, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1);
    run_instr(32'h0000_0301, 32'h1234_565A, 5'd15, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 0, 32'd0);

    // Timeout with no ack, then a late ack must be ignored
    exp_req(1'b0, 30'h100, 4'b1111, 32'h0000_0000);
    exp_wb(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 4);
    run_instr(32'h0000_0400, 32'd0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, -1, 32'd0);
    force_ack = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    force_ack = 1'b0;
    check("late_ack_req", 32'(MemReq), 32'd0);
    check("late_ack_stall", 32'(Stall), 32'd0);
    exp_wb(32'h0000_0077, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(32'h0000_0077, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1, 32'd0);

    // Reset while WAIT, then the same lw completes normally
    exp_req(1'b0, 30'h140, 4'b1111, 32'h0000_0000);
    apply(32'h0000_0500, 32'd0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, -1, 32'd0);
    repeat (2) begin @(negedge clk); #1; end
    check("pre_rst_req", 32'(MemReq), 32'd1);
    ex_valid = 1'b0;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(MemReq), 32'd0);
    check("mid_rst_stall", 32'(Stall), 32'd0);
    check("mid_rst_outs", {MemAddr, MemByteEn[1:0]}, 32'd0);
    check("mid_rst_wb", {WriteDataOut[31:6], rdRegOut, RegWriteOut}, 32'd0);
    @(negedge clk); #1;
    Rst_n = 1'b1;
    exp_req(1'b0, 30'h140, 4'b1111, 32'h0000_0000);
    exp_wb(32'h0BAD_F00D, 1'b1, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 3, 2);
    run_instr(32'h0000_0500, 32'd0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1, 32'h0BAD_F00D);

    repeat (4) @(negedge clk);
    #4;
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer side of the EX/MEM pipeline register; implements the MEM stage of the pipelined MIPS datapath.
- Takes the registered EX/MEM outputs: address (ALU result), store data, load/store controls, data type, writeback controls.
- Runs a variable-latency req/ack transaction to data memory, stalling upstream stages until the transaction completes.
- Drives the MEM/WB-side registered outputs: selected writeback data, destination register, register write enable.

Parameters:
- TIMEOUT_CYCLES, 16, WAIT cycles without MemAck before the transaction is aborted (range 1..255).

Ports:
- clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- ALUResultIn  in  32  byte address for loads/stores; writeback value for non-loads
- MemDataIn  in  32  store data, right-justified
- rdRegIn  in  5  destination register
- RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn  in  1 each  EX/MEM controls
- dataTypeIn  in  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- MemReq  out  1  request valid to data memory
- MemWe  out  1  1 = store
- MemAddr  out  30  word address, = address[31:2]
- MemByteEn  out  4  byte lane enables
- MemWData  out  32  lane-replicated store data
- MemRData  in  32  read data; valid when MemAck = 1
- MemAck  in  1  one-cycle completion strobe
- Stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM
- WriteDataOut  out  32  registered writeback data
- rdRegOut  out  5  registered destination register
- RegWriteOut  out  1  registered write enable
- AlignErr  out  1  registered one-cycle pulse on misaligned access
- BusErr  out  1  registered one-cycle pulse on timeout

Behaviour:
- Reset (asynchronous, Rst_n = 0) forces:
  - state IDLE, timeout counter 0;
  - MemReq, MemWe, MemAddr, MemByteEn, MemWData = 0;
  - WriteDataOut = 0, rdRegOut = 0, RegWriteOut = 0, AlignErr = 0, BusErr = 0.
  - Reset mid-transaction abandons it; any later MemAck is ignored while in IDLE.
- Access condition: access = MemReadIn | MemWriteIn. If both are set, the access is a store (write wins).
- Misaligned access:
  - word with address[1:0] != 0, or half with address[0] = 1;
  - no memory request is issued and Stall stays 0;
  - next edge registers AlignErr = 1, RegWriteOut = 0, rdRegOut = rdRegIn.
- Non-access instruction:
  - 1-cycle latency, Stall = 0;
  - WriteDataOut = ALUResultIn, RegWriteOut = RegWriteIn, rdRegOut = rdRegIn.
- States: IDLE, WAIT, DONE.
  - IDLE, aligned access:
    - Stall = 1;
    - next edge: go to WAIT, MemReq = 1, latch MemWe/MemAddr/MemByteEn/MemWData, counter = 0.
  - WAIT, Stall = 1:
    - MemAck = 1: MemReq <= 0, capture MemRData into an internal load buffer, go to DONE.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no ack: MemReq <= 0, BusErr pulses, RegWriteOut = 0, go to IDLE.
  - DONE, Stall = 0:
    - the edge registers the writeback outputs and returns to IDLE;
    - upstream advances on the same edge.
  - An ack arriving the same cycle the counter expires is accepted: ack beats timeout.
- Byte enables and store data:
  - word: 1111;
  - half: 0011 << address[1:0], MemWData = {2{MemDataIn[15:0]}};
  - byte: 0001 << address[1:0], MemWData = {4{MemDataIn[7:0]}}.
  - Byte lane 0 = bits [7:0] (little-endian).
- Load extraction:
  - select lane by address[1:0];
  - half sign-extends bit 15 of the lane;
  - byte type 10 sign-extends, type 11 zero-extends.
- Writeback:
  - MemToRegIn = 1 and load: WriteDataOut = extracted load data;
  - otherwise WriteDataOut = ALUResultIn.
  - Stores force RegWriteOut = 0 regardless of RegWriteIn.
- Pulse and handshake rules:
  - AlignErr and BusErr are high for exactly one cycle.
  - MemReq is held high until MemAck or timeout.
  - MemAck observed outside WAIT is ignored.

Test Plan:
- Non-memory pass-through: ALUResultIn = 0x0000_1234, RegWriteIn = 1, rdRegIn = 5 -> next edge WriteDataOut = 0x1234, rdRegOut = 5, RegWriteOut = 1, Stall never high.
- Signed byte load: lb (type 10) at address 0x103, MemRData = 0x80FF_0000, ack after 3 WAIT cycles -> Stall high 5 cycles, MemByteEn = 1000, WriteDataOut = 0xFFFF_FF80.
- Half store: sh (type 01) at 0x202, MemDataIn = 0xAAAA_BEEF, immediate ack -> MemAddr = 0x80, MemByteEn = 1100, MemWData = 0xBEEF_BEEF, MemWe = 1, RegWriteOut = 0.
- Misaligned word load: lw at 0x101 -> MemReq stays 0, AlignErr single pulse, RegWriteOut = 0, Stall 0.
- Timeout: TIMEOUT_CYCLES = 4, lw with no ack -> MemReq high exactly 4 cycles, BusErr pulse, return to IDLE; a late MemAck afterwards has no effect.
- Reset in WAIT: drop Rst_n while MemReq = 1 -> MemReq = 0 and Stall = 0 immediately, all outputs 0; the next lw completes normally.
